// File: rtl/wishbone_master.sv
`default_nettype none
// ============================================================================
// wishbone_master : single-outstanding Wishbone master with bounded error
//                   retry and per-attempt strobe timeout.
// Revision 1.0
// ============================================================================
module wishbone_master #(
    parameter int DATA_W  = 128,
    parameter int ADR_W   = 5,
    parameter int TIMEOUT = 16,
    parameter int RETRIES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_i,
    input  logic              req_we_i,
    input  logic [ADR_W-1:0]  req_adr_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              timeout_o,
    output logic              strobe,
    output logic              we_o,
    output logic [ADR_W-1:0]  adr_o,
    output logic [DATA_W-1:0] wb_data_o,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              ack_i,
    input  logic              error_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [2:0] RETRY_MAX = 3'(RETRIES);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  tmo_cnt;
    logic [2:0]  attempts;

    logic        accept;
    logic        bus_err;
    logic        bus_ack;
    logic        expired;
    logic        retry_ok;

    assign accept   = (state == S_IDLE) && req_i;
    // error dominates ack when the slave raises both in the same cycle
    assign bus_err  = (state == S_BUS) && error_i;
    assign bus_ack  = (state == S_BUS) && ack_i && !error_i;
    assign expired  = (tmo_cnt == TMO_LAST);
    assign retry_ok = (attempts < RETRY_MAX);

    assign strobe = (state == S_BUS);
    assign done_o = (state == S_DONE);
    assign busy_o = (state != S_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_i) begin
                    state_nxt = S_BUS;
                end
            end
            S_BUS: begin
                if (bus_err) begin
                    state_nxt = retry_ok ? S_GAP : S_DONE;
                end else if (bus_ack) begin
                    state_nxt = S_DONE;
                end else if (expired) begin
                    state_nxt = S_DONE;
                end
            end
            S_GAP:   state_nxt = S_BUS;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch: bus-side fields hold after completion so a slave that
    // ignores strobe still sees the last transaction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            we_o      <= 1'b0;
            adr_o     <= '0;
            wb_data_o <= '0;
        end else if (accept) begin
            we_o      <= req_we_i;
            adr_o     <= req_adr_i;
            wb_data_o <= req_data_i;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt  <= '0;
            attempts <= '0;
        end else if (accept) begin
            tmo_cnt  <= '0;
            attempts <= '0;
        end else if (state == S_GAP) begin
            tmo_cnt  <= '0;
        end else if (state == S_BUS) begin
            if (bus_err && retry_ok) begin
                attempts <= attempts + 3'd1;
            end else if (!bus_err && !bus_ack && !expired) begin
                tmo_cnt  <= tmo_cnt + 8'd1;
            end
        end
    end

    // Completion status is cleared on acceptance, so it stays readable
    // after done_o until the next request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_err_o  <= 1'b0;
            timeout_o  <= 1'b0;
            rsp_data_o <= '0;
        end else if (accept) begin
            rsp_err_o  <= 1'b0;
            timeout_o  <= 1'b0;
        end else if (state == S_BUS) begin
            if (bus_err) begin
                if (!retry_ok) begin
                    rsp_err_o <= 1'b1;
                end
            end else if (bus_ack) begin
                if (!we_o) begin
                    rsp_data_o <= wb_data_i;
                end
            end else if (expired) begin
                rsp_err_o <= 1'b1;
                timeout_o <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
